// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the RAM initiator: bus width defaults, wait-counter width
// and the controller state encoding.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Initiator for the 512x32 synchronous RAM: one request at a time, single-cycle strobes,
// optional wait cycles after the registered read, captured word held in rdata.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Terminal count of the wait counter; unused when READ_WAIT is zero.
  localparam logic [CNT_W-1:0] WAIT_LAST = (READ_WAIT > 0) ? CNT_W'(READ_WAIT - 1) : '0;

  state_t              state_q, state_d;
  logic                op_we_q, op_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_we_q <= op_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_we_d   = op_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_we_d = we;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_write = op_we_q;
        mem_read  = !op_we_q;
        cnt_d     = '0;
        if (op_we_q) begin
          state_d = ST_DONE;
        end else if (READ_WAIT > 0) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // RAM dataOut is valid from the cycle after the read edge onward.
        rdata_d = mem_rdata;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench: three controllers (READ_WAIT 0/2/3), each with its own RAM model, checked
// cycle by cycle against a transaction-level reference of memory contents and latency.
module tb_mem_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        clr_s, req_s, we_s, busy_s, done_s, rd_s, wr_s;
  logic [N-1:0][8:0]   addr_s, maddr_s;
  logic [N-1:0][31:0]  wdata_s, mwdata_s, rdata_s, mrdata_s;

  logic [31:0] model_mem [N][512];
  logic [31:0] exp_rdata [N];
  int total = 0;
  int bad   = 0;

  function automatic int rw_of(int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      logic [31:0] ram [512];
      logic [31:0] ram_out;

      initial begin
        for (int k = 0; k < 512; k++) ram[k] = '0;
        ram_out = '0;
      end

      always @(posedge clk) begin
        if (wr_s[gi]) ram[maddr_s[gi]] <= mwdata_s[gi];
        if (rd_s[gi]) ram_out <= ram[maddr_s[gi]];
      end
      assign mrdata_s[gi] = ram_out;

      mem_ctrl #(
        .ADDR_W   (9),
        .DATA_W   (32),
        .READ_WAIT(gi == 0 ? 0 : (gi == 1 ? 2 : 3))
      ) u_dut (
        .clk      (clk),
        .clr      (clr_s[gi]),
        .req      (req_s[gi]),
        .we       (we_s[gi]),
        .addr     (addr_s[gi]),
        .wdata    (wdata_s[gi]),
        .busy     (busy_s[gi]),
        .done     (done_s[gi]),
        .rdata    (rdata_s[gi]),
        .mem_read (rd_s[gi]),
        .mem_write(wr_s[gi]),
        .mem_addr (maddr_s[gi]),
        .mem_wdata(mwdata_s[gi]),
        .mem_rdata(mrdata_s[gi])
      );
    end
  endgenerate

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(int i, string tag);
    chk($sformatf("%s i%0d busy", tag, i), 32'(busy_s[i]), 32'd0);
    chk($sformatf("%s i%0d done", tag, i), 32'(done_s[i]), 32'd0);
    chk($sformatf("%s i%0d rd", tag, i), 32'(rd_s[i]), 32'd0);
    chk($sformatf("%s i%0d wr", tag, i), 32'(wr_s[i]), 32'd0);
  endtask

  // One request, started at a negedge with the controller idle. Ends at the negedge of
  // the first idle cycle after done. hold keeps req high; noise toggles inputs while busy.
  task automatic do_op(int i, bit w, logic [8:0] a, logic [31:0] d, bit hold, bit noise);
    int last;
    logic [31:0] pre;
    last = w ? 2 : 3 + rw_of(i);
    pre  = exp_rdata[i];
    if (w) model_mem[i][a] = d;
    else   exp_rdata[i] = model_mem[i][a];
    req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d;
    @(posedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      if (!hold) begin
        if (noise && c <= last) begin
          req_s[i]   = 1'($urandom_range(0, 1));
          we_s[i]    = 1'($urandom_range(0, 1));
          addr_s[i]  = 9'h0AA;
          wdata_s[i] = $urandom;
        end else begin
          req_s[i] = 1'b0;
        end
      end
      chk($sformatf("i%0d c%0d busy", i, c), 32'(busy_s[i]), 32'(c <= last));
      chk($sformatf("i%0d c%0d done", i, c), 32'(done_s[i]), 32'(c == last));
      chk($sformatf("i%0d c%0d wr", i, c), 32'(wr_s[i]), 32'(w && c == 1));
      chk($sformatf("i%0d c%0d rd", i, c), 32'(rd_s[i]), 32'(!w && c == 1));
      chk($sformatf("i%0d c%0d maddr", i, c), 32'(maddr_s[i]), 32'(a));
      chk($sformatf("i%0d c%0d mwdata", i, c), mwdata_s[i], d);
      chk($sformatf("i%0d c%0d rdata", i, c), rdata_s[i], (c < last) ? pre : exp_rdata[i]);
    end
    $display("op i=%0d we=%0d addr=%03h wdata=%08h rdata=%08h exp=%08h hold=%0d noise=%0d",
             i, w, a, d, rdata_s[i], exp_rdata[i], hold, noise);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 512; k++) model_mem[i][k] = '0;
      exp_rdata[i] = '0;
    end
    clr_s = '1; req_s = '0; we_s = '0; addr_s = '0; wdata_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk_idle(i, "reset");
      chk($sformatf("reset i%0d rdata", i), rdata_s[i], 32'd0);
      chk($sformatf("reset i%0d maddr", i), 32'(maddr_s[i]), 32'd0);
      chk($sformatf("reset i%0d mwdata", i), mwdata_s[i], 32'd0);
    end
    clr_s = '0;
    @(negedge clk);

    // Basic write then read-back, no wait cycles.
    do_op(0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 1'b0);
    do_op(0, 1'b0, 9'h005, 32'h0000_0001, 1'b0, 1'b0);
    // req held high across a write and the following read.
    do_op(0, 1'b1, 9'h1FF, 32'hA5C3_0F96, 1'b1, 1'b0);
    do_op(0, 1'b0, 9'h1FF, 32'h0000_0002, 1'b0, 1'b0);
    // Spurious requests while busy must not disturb the latched address.
    do_op(1, 1'b1, 9'h010, 32'h0BAD_F00D, 1'b0, 1'b1);
    do_op(1, 1'b0, 9'h010, 32'h0000_0003, 1'b0, 1'b1);
    // Two wait cycles: done in cycle 5.
    do_op(1, 1'b1, 9'h000, 32'h12345678, 1'b0, 1'b0);
    do_op(1, 1'b0, 9'h000, 32'h0000_0004, 1'b0, 1'b0);

    // Reset during WAIT of a read on the READ_WAIT=3 instance.
    do_op(2, 1'b1, 9'h033, 32'hCAFE_1234, 1'b0, 1'b0);
    do_op(2, 1'b0, 9'h033, 32'h0000_0005, 1'b0, 1'b0);
    req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 9'h034; wdata_s[2] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_s[2] = 1'b0;
    chk("abort access rd", 32'(rd_s[2]), 32'd1);
    @(negedge clk);
    chk("abort wait busy", 32'(busy_s[2]), 32'd1);
    chk("abort wait rd", 32'(rd_s[2]), 32'd0);
    clr_s[2] = 1'b1;
    @(negedge clk);
    clr_s[2] = 1'b0;
    exp_rdata[2] = '0;
    chk_idle(2, "abort");
    chk("abort rdata", rdata_s[2], 32'd0);
    chk("abort maddr", 32'(maddr_s[2]), 32'd0);
    chk("abort mwdata", mwdata_s[2], 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_idle(2, $sformatf("post-abort%0d", k));
    end
    $display("abort i=2 rdata=%08h busy=%0d", rdata_s[2], busy_s[2]);

    // clr and req together: the request is dropped.
    clr_s[0] = 1'b1; req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 9'h007; wdata_s[0] = 32'h7777;
    @(negedge clk);
    clr_s[0] = 1'b0; req_s[0] = 1'b0;
    exp_rdata[0] = '0;
    for (int k = 0; k < 3; k++) begin
      chk_idle(0, $sformatf("clr+req%0d", k));
      chk($sformatf("clr+req%0d maddr", k), 32'(maddr_s[0]), 32'd0);
      @(negedge clk);
    end
    $display("clr+req i=0 busy=%0d maddr=%03h", busy_s[0], maddr_s[0]);
    do_op(0, 1'b0, 9'h007, 32'h0000_0006, 1'b0, 1'b0);

    // Randomized traffic; small address window so reads often hit earlier writes.
    for (int n = 0; n < 60; n++) begin
      int i;
      logic [8:0] a;
      i = $urandom_range(0, N - 1);
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      do_op(i, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
